// File: rtl/rxsync_pkg.sv
// Shared types and constants for the access-code sync correlator.
// The state encoding is also used by the bench to read the debug state port.
package rxsync_pkg;

    localparam int SYNC_LEN = 64;
    localparam int ERR_W    = 7;
    localparam int WIN_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_FOUND  = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

endpackage

// File: rtl/rxsyncdet_popcount64.sv
// Combinational ones-counter over 64 bits, built as a balanced adder tree
// so the critical path is six adder levels rather than a 64-deep chain.
module popcount64 (
    input  logic [63:0] vec_i,
    output logic [6:0]  cnt_o
);

    logic [1:0] lvl1 [32];
    logic [2:0] lvl2 [16];
    logic [3:0] lvl3 [8];
    logic [4:0] lvl4 [4];
    logic [5:0] lvl5 [2];

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            lvl1[i] = {1'b0, vec_i[2*i]} + {1'b0, vec_i[2*i+1]};
        end
        for (int i = 0; i < 16; i++) begin
            lvl2[i] = {1'b0, lvl1[2*i]} + {1'b0, lvl1[2*i+1]};
        end
        for (int i = 0; i < 8; i++) begin
            lvl3[i] = {1'b0, lvl2[2*i]} + {1'b0, lvl2[2*i+1]};
        end
        for (int i = 0; i < 4; i++) begin
            lvl4[i] = {1'b0, lvl3[2*i]} + {1'b0, lvl3[2*i+1]};
        end
        for (int i = 0; i < 2; i++) begin
            lvl5[i] = {1'b0, lvl4[2*i]} + {1'b0, lvl4[2*i+1]};
        end
        cnt_o = {1'b0, lvl5[0]} + {1'b0, lvl5[1]};
    end

endmodule

// File: rtl/rxsyncdet.sv
// Access-code correlator: slides the last 64 received bits against the sync
// word, flags the first position within tolerance, then marks the trailer start.
module rxsyncdet #(
    parameter int SYNC_LEN = 64
) (
    input  logic                       clk_6M,
    input  logic                       rstz,
    input  logic                       p_1us,
    input  logic                       rxbit,
    input  logic                       search_start_p,
    input  logic                       search_stop_p,
    input  logic [SYNC_LEN-1:0]        regi_syncword,
    input  logic [rxsync_pkg::ERR_W-1:0] regi_corr_thresh,
    input  logic [rxsync_pkg::WIN_W-1:0] regi_search_win,
    output logic                       rx_trailer_st_p,
    output logic                       sync_found,
    output logic                       timeout_p,
    output logic [rxsync_pkg::ERR_W-1:0] corr_errs,
    output logic                       searching,
    output logic [1:0]                 dbg_state
);

    import rxsync_pkg::*;

    localparam logic [ERR_W-1:0] FILL_FULL = ERR_W'(SYNC_LEN);

    state_t              state_q, state_d;
    logic [SYNC_LEN-1:0] shift_q, shift_d, shift_next;
    logic [ERR_W-1:0]    fill_q, fill_d, fill_next;
    logic [WIN_W-1:0]    win_q, win_d;
    logic [ERR_W-1:0]    corr_errs_q, corr_errs_d;
    logic [ERR_W-1:0]    errs;
    logic                match, timeout;

    // Correlate against the register value *including* the bit arriving now,
    // so the decision lands in the same cycle as the last sync bit.
    assign shift_next = {rxbit, shift_q[SYNC_LEN-1:1]};

    popcount64 u_popcount (
        .vec_i (shift_next ^ regi_syncword),
        .cnt_o (errs)
    );

    always_comb begin
        fill_next = (fill_q >= FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
        match     = (state_q == ST_SEARCH) && p_1us &&
                    (fill_next == FILL_FULL) && (errs <= regi_corr_thresh);
        // A zero window never reaches 1, which is what makes 0 mean unlimited.
        timeout   = (state_q == ST_SEARCH) && p_1us &&
                    (win_q == WIN_W'(1)) && !match;
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        fill_d      = fill_q;
        win_d       = win_q;
        corr_errs_d = corr_errs_q;

        if (search_stop_p) begin
            state_d = ST_IDLE;
        end else if (search_start_p) begin
            state_d = ST_SEARCH;
            shift_d = '0;
            fill_d  = '0;
            win_d   = regi_search_win;
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    if (p_1us) begin
                        shift_d = shift_next;
                        fill_d  = fill_next;
                        if (win_q != '0) begin
                            win_d = win_q - 1'b1;
                        end
                        if (match) begin
                            state_d     = ST_FOUND;
                            corr_errs_d = errs;
                        end else if (timeout) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_FOUND: begin
                    if (p_1us) begin
                        state_d = ST_LOCKED;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            fill_q      <= '0;
            win_q       <= '0;
            corr_errs_q <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            fill_q      <= fill_d;
            win_q       <= win_d;
            corr_errs_q <= corr_errs_d;
        end
    end

    assign rx_trailer_st_p = (state_q == ST_FOUND) && p_1us;
    assign timeout_p       = timeout;
    assign sync_found      = (state_q == ST_LOCKED);
    assign searching       = (state_q == ST_SEARCH);
    assign corr_errs       = corr_errs_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_rxsyncdet.sv
// Directed bench for rxsyncdet: expected trailer/timeout events are queued by
// the stimulus and matched by an independent monitor.
module tb_rxsyncdet;

    import rxsync_pkg::*;

    localparam logic [63:0] SYNC_A = 64'hA5C3_96E1_0F3C_5A69;

    logic        clk_6M = 1'b0;
    logic        rstz = 1'b0;
    logic        p_1us = 1'b0;
    logic        rxbit = 1'b0;
    logic        search_start_p = 1'b0;
    logic        search_stop_p = 1'b0;
    logic [63:0] regi_syncword = '0;
    logic [6:0]  regi_corr_thresh = '0;
    logic [15:0] regi_search_win = '0;
    logic        rx_trailer_st_p;
    logic        sync_found;
    logic        timeout_p;
    logic [6:0]  corr_errs;
    logic        searching;
    logic [1:0]  dbg_state;

    int          n_vec = 0;
    int          n_err = 0;
    int          cur_bit = 0;
    logic [39:0] exp_q[$];
    logic [39:0] got_ev;
    logic [39:0] exp_ev;

    rxsyncdet #(.SYNC_LEN(64)) dut (
        .clk_6M           (clk_6M),
        .rstz             (rstz),
        .p_1us            (p_1us),
        .rxbit            (rxbit),
        .search_start_p   (search_start_p),
        .search_stop_p    (search_stop_p),
        .regi_syncword    (regi_syncword),
        .regi_corr_thresh (regi_corr_thresh),
        .regi_search_win  (regi_search_win),
        .rx_trailer_st_p  (rx_trailer_st_p),
        .sync_found       (sync_found),
        .timeout_p        (timeout_p),
        .corr_errs        (corr_errs),
        .searching        (searching),
        .dbg_state        (dbg_state)
    );

    always #83 clk_6M = ~clk_6M;

    // Event encoding: {is_timeout, corr_errs, bit index since search start}
    function automatic logic [39:0] mk_ev(input logic is_to, input logic [6:0] errs, input int bitn);
        return {is_to, errs, 32'(bitn)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_6M);
        #1;
    endtask

    task automatic send_bit(input logic b);
        p_1us = 1'b1;
        rxbit = b;
        cur_bit++;
        tick();
        p_1us = 1'b0;
        repeat (5) tick();
    endtask

    task automatic send_word(input logic [63:0] w, input logic [63:0] flips);
        for (int i = 0; i < 64; i++) send_bit(w[i] ^ flips[i]);
    endtask

    task automatic send_noise(input int n);
        for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
    endtask

    task automatic send_const(input int n, input logic b);
        for (int i = 0; i < n; i++) send_bit(b);
    endtask

    task automatic do_stop();
        search_stop_p = 1'b1;
        tick();
        search_stop_p = 1'b0;
    endtask

    task automatic do_start(input logic [63:0] w, input logic [6:0] th, input logic [15:0] win);
        do_stop();
        regi_syncword    = w;
        regi_corr_thresh = th;
        regi_search_win  = win;
        tick();
        cur_bit = 0;
        search_start_p = 1'b1;
        tick();
        search_start_p = 1'b0;
    endtask

    task automatic check_drained(input string name);
        check(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Monitor: every trailer/timeout pulse is matched against the queue head.
    always @(negedge clk_6M) begin
        if (rstz && (rx_trailer_st_p || timeout_p)) begin
            got_ev = {timeout_p, (rx_trailer_st_p ? corr_errs : 7'd0), 32'(cur_bit)};
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event: got %h expected none", got_ev);
            end else begin
                exp_ev = exp_q.pop_front();
                if (got_ev !== exp_ev || (rx_trailer_st_p && timeout_p)) begin
                    n_err++;
                    $display("FAIL event: got %h expected %h", got_ev, exp_ev);
                end
            end
        end
    end

    initial begin
        // Reset state
        #40;
        check("rst_searching", 64'(searching), 64'd0);
        check("rst_sync_found", 64'(sync_found), 64'd0);
        check("rst_trailer", 64'(rx_trailer_st_p), 64'd0);
        check("rst_timeout", 64'(timeout_p), 64'd0);
        check("rst_corr_errs", 64'(corr_errs), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        tick();
        rstz = 1'b1;
        tick();

        // Exact sync after 20 random bits, thresh 0: trailer at bit 20+64+1
        do_start(SYNC_A, 7'd0, 16'd200);
        check("s1_searching", 64'(searching), 64'd1);
        exp_q.push_back(mk_ev(1'b0, 7'd0, 85));
        send_noise(20);
        send_word(SYNC_A, 64'd0);
        check("s1_found_state", 64'(dbg_state), 64'(ST_FOUND));
        send_bit(1'b0);
        check("s1_sync_found", 64'(sync_found), 64'd1);
        check("s1_corr_errs", 64'(corr_errs), 64'd0);
        check_drained("s1_pending");

        // Three flipped bits, thresh 3: lock with 3 errors; stop releases lock
        do_start(SYNC_A, 7'd3, 16'd120);
        exp_q.push_back(mk_ev(1'b0, 7'd3, 85));
        send_const(20, 1'b0);
        send_word(SYNC_A, 64'h2000_0000_4000_0020);
        send_bit(1'b1);
        send_bit(1'b0);
        check("s2_locked", 64'(sync_found), 64'd1);
        check("s2_corr_errs", 64'(corr_errs), 64'd3);
        do_stop();
        check("s2_stop_sync_found", 64'(sync_found), 64'd0);
        check("s2_stop_state", 64'(dbg_state), 64'(ST_IDLE));
        check_drained("s2_pending");

        // Same stream, thresh 2: no lock, timeout on the 120th bit
        do_start(SYNC_A, 7'd2, 16'd120);
        exp_q.push_back(mk_ev(1'b1, 7'd0, 120));
        send_const(20, 1'b0);
        send_word(SYNC_A, 64'h2000_0000_4000_0020);
        send_const(36, 1'b0);
        check("s3_no_lock", 64'(sync_found), 64'd0);
        check("s3_idle", 64'(dbg_state), 64'(ST_IDLE));
        check("s3_corr_errs_held", 64'(corr_errs), 64'd3);
        check_drained("s3_pending");

        // Noise only, window 100: timeout on the 100th bit, searching drops
        do_start(SYNC_A, 7'd0, 16'd100);
        exp_q.push_back(mk_ev(1'b1, 7'd0, 100));
        send_noise(99);
        check("s4_still_searching", 64'(searching), 64'd1);
        send_noise(1);
        check("s4_searching_low", 64'(searching), 64'd0);
        check("s4_idle", 64'(dbg_state), 64'(ST_IDLE));
        send_noise(5);
        check_drained("s4_pending");

        // Stop and start together in SEARCH: stop wins
        do_start(SYNC_A, 7'd0, 16'd0);
        send_noise(10);
        search_stop_p  = 1'b1;
        search_start_p = 1'b1;
        tick();
        search_stop_p  = 1'b0;
        search_start_p = 1'b0;
        check("s5_searching", 64'(searching), 64'd0);
        check("s5_idle", 64'(dbg_state), 64'(ST_IDLE));

        // Asynchronous reset mid-search clears everything at once
        do_start(SYNC_A, 7'd0, 16'd0);
        send_noise(10);
        check("s6_pre_searching", 64'(searching), 64'd1);
        #20;
        rstz = 1'b0;
        #1;
        check("s6_searching", 64'(searching), 64'd0);
        check("s6_sync_found", 64'(sync_found), 64'd0);
        check("s6_corr_errs", 64'(corr_errs), 64'd0);
        check("s6_state", 64'(dbg_state), 64'(ST_IDLE));
        tick();
        rstz = 1'b1;
        tick();

        // All-zero word and stream: match only once 64 bits have been seen
        do_start(64'd0, 7'd0, 16'd0);
        exp_q.push_back(mk_ev(1'b0, 7'd0, 65));
        send_const(63, 1'b0);
        check("s7_no_early_match", 64'(dbg_state), 64'(ST_SEARCH));
        send_bit(1'b0);
        check("s7_found", 64'(dbg_state), 64'(ST_FOUND));
        send_bit(1'b0);
        check("s7_locked", 64'(sync_found), 64'd1);
        check_drained("s7_pending");

        // Unlimited window, sync starting at bit 5000
        do_start(SYNC_A, 7'd0, 16'd0);
        exp_q.push_back(mk_ev(1'b0, 7'd0, 5064));
        send_noise(4999);
        check("s8_still_searching", 64'(searching), 64'd1);
        send_word(SYNC_A, 64'd0);
        send_bit(1'b1);
        check("s8_locked", 64'(sync_found), 64'd1);
        check("s8_corr_errs", 64'(corr_errs), 64'd0);
        check_drained("s8_pending");
        do_stop();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
